// File: rtl/imem_server_pkg.sv
// Shared types and constants for the instruction-memory server.
package imem_server_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHalt = 2'd3
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;
    localparam logic [31:0] NOP               = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Program storage: synchronous write, combinational read, contents never reset.
module imem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_server.sv
// Loads a program over a valid/ready stream, then serves combinational fetches to a CPU
// until a halt word, the cycle watchdog, or a reset ends the run.
module imem_server
    import imem_server_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_start,
    input  logic          i_ld_valid,
    input  logic [31:0]   i_ld_data,
    input  logic          i_ld_last,
    output logic          o_ld_ready,
    input  logic          i_run_start,
    input  logic [31:0]   i_pc,
    output logic [31:0]   o_inst,
    output logic          o_pc_en,
    output logic [1:0]    o_state,
    output logic [AW:0]   o_prog_len,
    output logic [15:0]   o_run_cycles,
    output logic          o_halted,
    output logic          o_load_err,
    output logic          o_fetch_err,
    output logic          o_timeout
);

    state_e        r_state;
    state_e        w_state_d;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_prog_len;
    logic [15:0]   r_run_cycles;
    logic          r_halted, r_load_err, r_fetch_err, r_timeout;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;
    logic [15:0]   w_run_cycles_inc;
    logic          w_unused_pc_lsb;
    logic          w_idle_like, w_start_load, w_start_run, w_accept, w_ptr_end;
    logic          w_run, w_oob, w_fetch_ok, w_halt_hit, w_timeout_hit;

    assign w_idx           = i_pc[AW+1:2];
    assign w_unused_pc_lsb = ^i_pc[1:0];
    assign w_oob           = |i_pc[31:AW+2];
    assign w_run           = (r_state == StRun);
    assign w_fetch_ok      = w_run && !w_oob && ({1'b0, w_idx} < r_prog_len);
    assign w_halt_hit      = w_fetch_ok && (w_rdata == HALT_WORD);

    assign w_idle_like  = (r_state == StIdle) || (r_state == StHalt);
    assign w_start_load = w_idle_like && i_load_start;
    assign w_start_run  = w_idle_like && !i_load_start && i_run_start;
    assign w_accept     = (r_state == StLoad) && i_ld_valid;
    assign w_ptr_end    = (r_ptr == AW'(DEPTH - 1));

    assign w_run_cycles_inc = (&r_run_cycles) ? r_run_cycles : r_run_cycles + 16'd1;
    assign w_timeout_hit    = w_run && (w_run_cycles_inc == MAX_CYCLES);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem_array (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_waddr (r_ptr),
        .i_wdata (i_ld_data),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StHalt: begin
                if (i_load_start)     w_state_d = StLoad;
                else if (i_run_start) w_state_d = StRun;
            end
            StLoad: if (w_accept && (i_ld_last || w_ptr_end)) w_state_d = StIdle;
            StRun:  if (w_halt_hit || w_timeout_hit)          w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ld_ready = (r_state == StLoad);
        o_pc_en    = w_run;
        o_inst     = (w_fetch_ok && !w_halt_hit) ? w_rdata : NOP;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_prog_len   <= '0;
            r_run_cycles <= '0;
            r_halted     <= 1'b0;
            r_load_err   <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_ptr      <= '0;
                r_prog_len <= '0;
                r_load_err <= 1'b0;
            end
            if (w_start_run) begin
                r_run_cycles <= '0;
                r_halted     <= 1'b0;
                r_fetch_err  <= 1'b0;
                r_timeout    <= 1'b0;
            end
            if (w_accept) begin
                r_prog_len <= r_prog_len + (AW+1)'(1);
                // The pointer parks at the last slot rather than wrapping onto word 0.
                if (!w_ptr_end) r_ptr <= r_ptr + AW'(1);
                if (w_ptr_end && !i_ld_last) r_load_err <= 1'b1;
            end
            if (w_run) begin
                r_run_cycles <= w_run_cycles_inc;
                if (w_oob)         r_fetch_err <= 1'b1;
                if (w_halt_hit)    r_halted    <= 1'b1;
                if (w_timeout_hit) r_timeout   <= 1'b1;
            end
        end
    end

    assign o_state      = r_state;
    assign o_prog_len   = r_prog_len;
    assign o_run_cycles = r_run_cycles;
    assign o_halted     = r_halted;
    assign o_load_err   = r_load_err;
    assign o_fetch_err  = r_fetch_err;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: load, run-to-halt, fetch errors, watchdog, resets.
module tb_imem_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, run_start = 1'b0;
    logic [31:0] ld_data = '0, pc = '0;
    logic        ld_ready, pc_en, halted, load_err, fetch_err, timeout;
    logic [31:0] inst;
    logic [1:0]  state;
    logic [6:0]  prog_len;
    logic [15:0] run_cycles;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    imem_server #(
        .DEPTH      (64),
        .HALT_WORD  (32'hFC00_0000),
        .MAX_CYCLES (16'd10)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_start (load_start),
        .i_ld_valid   (ld_valid),
        .i_ld_data    (ld_data),
        .i_ld_last    (ld_last),
        .o_ld_ready   (ld_ready),
        .i_run_start  (run_start),
        .i_pc         (pc),
        .o_inst       (inst),
        .o_pc_en      (pc_en),
        .o_state      (state),
        .o_prog_len   (prog_len),
        .o_run_cycles (run_cycles),
        .o_halted     (halted),
        .o_load_err   (load_err),
        .o_fetch_err  (fetch_err),
        .o_timeout    (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic ld, input logic rn);
        load_start = ld;
        run_start  = rn;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, inst, exp);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_flags", {28'd0, halted, load_err, fetch_err, timeout}, 32'd0);
        rst = 1'b0;

        // load_start beats run_start; a bubble cycle must not count as a word
        pulse_start(1'b1, 1'b1);
        check("load_enter_state", 32'(state), 32'd1);
        check("load_ld_ready", 32'(ld_ready), 32'd1);
        load_word(32'h2001_0005, 1'b0);
        tick();
        check("load_bubble_len", 32'(prog_len), 32'd1);
        load_word(32'h2002_0003, 1'b0);
        load_word(32'h0022_1820, 1'b0);
        load_word(32'hFC00_0000, 1'b1);
        check("load4_state", 32'(state), 32'd0);
        check("load4_len", 32'(prog_len), 32'd4);
        check("load4_err", 32'(load_err), 32'd0);
        check("load4_ld_ready", 32'(ld_ready), 32'd0);

        // run to the halt word; pc=5 exercises ignored byte-offset bits
        pulse_start(1'b0, 1'b1);
        check("run_state", 32'(state), 32'd2);
        check("run_pc_en", 32'(pc_en), 32'd1);
        fetch("run_inst0", 32'd0, 32'h2001_0005);
        fetch("run_inst1", 32'd5, 32'h2002_0003);
        fetch("run_inst2", 32'd8, 32'h0022_1820);
        fetch("run_inst3_halt", 32'd12, 32'h0);
        check("halt_state", 32'(state), 32'd3);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc_en", 32'(pc_en), 32'd0);
        check("halt_cycles", 32'(run_cycles), 32'd4);
        check("halt_inst", inst, 32'h0);

        // out-of-range fetch, beyond-program fetch, then watchdog expiry
        pulse_start(1'b0, 1'b1);
        check("rerun_halted_clr", 32'(halted), 32'd0);
        fetch("oob_inst", 32'h0000_0100, 32'h0);
        check("oob_fetch_err", 32'(fetch_err), 32'd1);
        check("oob_pc_en", 32'(pc_en), 32'd1);
        pc = 32'd16;
        #1;
        check("beyond_len_inst", inst, 32'h0);
        cyc = 0;
        while (state != 2'd3 && cyc < 30) begin
            tick();
            cyc++;
        end
        check("timeout_cycles_waited", cyc, 32'd9);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_run_cycles", 32'(run_cycles), 32'd10);
        check("timeout_halted", 32'(halted), 32'd0);
        check("timeout_fetch_err_sticky", 32'(fetch_err), 32'd1);

        // asynchronous reset in the third RUN cycle
        pulse_start(1'b0, 1'b1);
        check("rerun_clears", {28'd0, halted, load_err, fetch_err, timeout}, 32'd0);
        fetch("mid_inst0", 32'd0, 32'h2001_0005);
        fetch("mid_inst1", 32'd4, 32'h2002_0003);
        check("mid_cycles", 32'(run_cycles), 32'd2);
        pc = 32'd8;
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_pc_en", 32'(pc_en), 32'd0);
        check("arst_cycles", 32'(run_cycles), 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_len", 32'(prog_len), 32'd0);
        rst = 1'b0;

        // reload a shorter program and rerun
        pulse_start(1'b1, 1'b0);
        load_word(32'h2001_0005, 1'b0);
        load_word(32'h2002_0003, 1'b1);
        pulse_start(1'b0, 1'b1);
        fetch("reload_inst0", 32'd0, 32'h2001_0005);
        fetch("reload_inst1", 32'd4, 32'h2002_0003);
        fetch("reload_past_len", 32'd8, 32'h0);
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // fill every slot without ld_last
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            load_word(32'h1000_0000 + 32'(i), 1'b0);
            if (i == 62) check("full_still_loading", 32'(state), 32'd1);
        end
        check("full_state", 32'(state), 32'd0);
        check("full_len", 32'(prog_len), 32'd64);
        check("full_load_err", 32'(load_err), 32'd1);
        // ld_valid outside LOAD must not advance anything
        load_word(32'hDEAD_BEEF, 1'b1);
        check("idle_valid_ignored", 32'(prog_len), 32'd64);
        pulse_start(1'b0, 1'b1);
        fetch("full_last_word", 32'd252, 32'h1000_003F);
        fetch("full_first_word", 32'd0, 32'h1000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_server.md
IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit program words (power of 2; address bits AW = log2(DEPTH)).
REQ-002 Parameter: HALT_WORD, 32'hFC00_0000, instruction encoding that ends a run.
REQ-003 Parameter: MAX_CYCLES, 16'hFFFF, run-cycle watchdog limit.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load_start  in  1  pulse: enter LOAD from IDLE.
REQ-007 ld_valid  in  1  program word valid.
REQ-008 ld_data  in  32  program word.
REQ-009 ld_last  in  1  marks final program word.
REQ-010 ld_ready  out  1  server accepts a word this cycle.
REQ-011 run_start  in  1  pulse: enter RUN from IDLE.
REQ-012 pc  in  32  CPU fetch address.
REQ-013 inst  out  32  instruction returned for pc, combinational, same cycle.
REQ-014 pcEn  out  1  CPU PC-advance enable.
REQ-015 state  out  2  current FSM state.
REQ-016 prog_len  out  AW+1  words loaded by last load.
REQ-017 run_cycles  out  16  cycles spent in RUN.
REQ-018 halted, load_err, fetch_err, timeout  out  1 each  status flags.

Function
REQ-019 FSM SHALL have states IDLE=0, LOAD=1, RUN=2, HALT=3.
REQ-020 IDLE: load_start -> LOAD (clears prog_len, load pointer, load_err); else run_start -> RUN (clears run_cycles, halted, fetch_err, timeout); load_start wins if both.
REQ-021 LOAD: ld_ready SHALL be 1; each cycle with ld_valid=1 SHALL write ld_data to mem[ptr], increment ptr and prog_len.
REQ-022 LOAD exits to IDLE the cycle after an accepted word with ld_last=1.
REQ-023 Accepted word at ptr=DEPTH-1 without ld_last SHALL be written, set load_err, exit to IDLE (no pointer wrap).
REQ-024 ld_ready SHALL be 0 in every state other than LOAD; ld_valid outside LOAD is ignored.
REQ-025 RUN: pcEn=1; inst = mem[pc[AW+1:2]]; pc[1:0] ignored.
REQ-026 RUN: if pc[31:AW+2] != 0, inst SHALL be 32'h0 (NOP) and fetch_err SHALL set (sticky until next run_start).
REQ-027 RUN: if word index >= prog_len, inst SHALL be 32'h0 (no fetch_err).
REQ-028 RUN: if selected word equals HALT_WORD, inst SHALL be 32'h0 that cycle and FSM -> HALT next cycle, halted=1.
REQ-029 RUN: run_cycles increments every RUN cycle, saturating at 16'hFFFF; reaching MAX_CYCLES SHALL set timeout and enter HALT.
REQ-030 HALT: pcEn=0, inst=32'h0; run_start or load_start returns to IDLE-equivalent entry (same action as from IDLE, same priority).
REQ-031 IDLE/LOAD: pcEn=0, inst=32'h0.
REQ-032 Memory contents SHALL persist across runs and resets; only LOAD writes it.

Reset
REQ-033 reset SHALL asynchronously force state=IDLE, ptr=0, prog_len=0, run_cycles=0, all flags=0, ld_ready=0, pcEn=0, inst=0.
REQ-034 reset asserted mid-LOAD or mid-RUN SHALL abort immediately; a partial load keeps written words but prog_len=0.

Structure
REQ-035 Shared package SHALL hold the state enum type, HALT_WORD default, and NOP constant 32'h0.
REQ-036 One sub-module, imem_array (DEPTH x 32, synchronous write, combinational read, no reset), is natural.

Verification
REQ-037 Load 4 words {20010005, 20020003, 00221820, FC000000} with ld_last on 4th -> prog_len=4, state IDLE, load_err=0.
REQ-038 run_start, pc=0,4,8,12 -> inst=20010005, 20020003, 00221820, 0; halted=1 and pcEn=0 next cycle, run_cycles=4.
REQ-039 Load DEPTH words, no ld_last -> load_err=1, prog_len=DEPTH, IDLE after last word.
REQ-040 RUN with pc=32'h0000_0100 (DEPTH=64) -> inst=0, fetch_err=1, pcEn stays 1.
REQ-041 MAX_CYCLES=10, program without HALT_WORD -> timeout=1, HALT after 10 RUN cycles, inst=0 beyond prog_len.
REQ-042 reset pulse mid-RUN (cycle 3) -> state=IDLE, pcEn=0, run_cycles=0 without waiting for clk; rerun returns same instructions.
